// File: rtl/branch_resolve_pkg.sv
// Shared types and constants for the execute-side branch resolution slice.
//   N            : execute lanes per cycle (lane 0 oldest)
//   XLEN         : PC width
//   EX_BR_RESULT : one resolved control-flow result from execute
//   EX_BP_PACKET : one predictor-training record
// Helper functions derive the actual next PC and the training record of a
// result, so the resolver and anything else that needs them agree exactly.
package branch_resolve_pkg;

  localparam int XLEN = 32;
  localparam int N    = 4;

  typedef struct packed {
    logic            valid;
    logic            cond_branch;
    logic            uncond_branch;
    logic            taken;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] pred_NPC;
    logic [XLEN-1:0] target_PC;
  } EX_BR_RESULT;

  typedef struct packed {
    logic            cond_branch_en;
    logic            branch_en;
    logic            cond_branch_taken;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] target_PC;
  } EX_BP_PACKET;

  // Unconditional branches always redirect; PC + 4 wraps at 2^XLEN.
  function automatic logic actual_taken(input EX_BR_RESULT r);
    return r.uncond_branch | r.taken;
  endfunction

  function automatic logic [XLEN-1:0] actual_npc(input EX_BR_RESULT r);
    return actual_taken(r) ? r.target_PC : r.PC + XLEN'(4);
  endfunction

  function automatic EX_BP_PACKET make_record(input EX_BR_RESULT r);
    EX_BP_PACKET p;
    p.cond_branch_en    = r.cond_branch;
    p.branch_en         = actual_taken(r);
    p.cond_branch_taken = r.taken & r.cond_branch;
    p.PC                = r.PC;
    p.target_PC         = r.target_PC;
    return p;
  endfunction

endpackage

// File: rtl/br_train_fifo.sv
// Multi-enqueue / multi-dequeue circular buffer of predictor-training records.
//   clock, reset : single clock, synchronous active-high reset
//   enq_valid    : per-lane write request; set lanes are packed in lane order
//   enq_data     : per-lane record
//   deq_data     : the min(count, UPD_W) oldest records in lanes 0.., rest zero
//   count        : occupied entries, 0..DEPTH
// Space freed by this cycle's dequeue is only visible to enqueue next cycle.
// Lanes that do not fit are dropped; that case is flagged by an assertion.
module br_train_fifo
  import branch_resolve_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LANES = N,
  parameter int UPD_W = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [LANES-1:0]       enq_valid,
  input  EX_BP_PACKET            enq_data [LANES],
  output EX_BP_PACKET            deq_data [LANES],
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  EX_BP_PACKET      mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] free_slots;
  logic [CNT_W-1:0] enq_num;
  logic [CNT_W-1:0] deq_num;
  logic [DEPTH-1:0] wr_en;
  EX_BP_PACKET      wr_data [DEPTH];
  logic [PTR_W-1:0] wr_idx;
  logic             overflow;

  assign free_slots = CNT_W'(DEPTH) - count;
  assign deq_num    = (count < CNT_W'(UPD_W)) ? count : CNT_W'(UPD_W);

  // Compact the requesting lanes onto consecutive slots starting at tail.
  // NOTE: enq_num is a running tally, so it is updated with blocking
  // assignments inside this combinational loop and defaulted first to avoid
  // latches.
  always_comb begin
    wr_en    = '0;
    enq_num  = '0;
    wr_idx   = '0;
    overflow = 1'b0;
    for (int d = 0; d < DEPTH; d++) wr_data[d] = '0;
    for (int i = 0; i < LANES; i++) begin
      if (enq_valid[i]) begin
        if (enq_num < free_slots) begin
          wr_idx          = tail + enq_num[PTR_W-1:0];
          wr_en[wr_idx]   = 1'b1;
          wr_data[wr_idx] = enq_data[i];
          enq_num         = enq_num + CNT_W'(1);
        end else begin
          overflow = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      deq_data[j] = '0;
      if (CNT_W'(j) < deq_num) deq_data[j] = mem[head + PTR_W'(j)];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + deq_num[PTR_W-1:0];
      tail  <= tail + enq_num[PTR_W-1:0];
      count <= count + enq_num - deq_num;
    end
  end

  // NOTE: storage has no reset; every read is gated by count, so stale
  // contents are never observable and the array can map to plain flops/RAM.
  always_ff @(posedge clock) begin
    for (int d = 0; d < DEPTH; d++) begin
      if (wr_en[d]) mem[d] <= wr_data[d];
    end
  end

  // Upstream must hold branches while br_full is high.
  always_ff @(posedge clock) begin
    if (!reset) assert (!overflow);
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-side branch resolution and predictor-training unit.
//   clock, reset     : single clock, synchronous active-high reset
//   ex_br_in         : N resolved results per cycle, lane 0 oldest
//   ex_bp_packet_out : up to UPD_W training records per cycle, oldest first
//   squash_flag      : registered one-cycle flush on the oldest mispredict
//   squash_pc        : registered redirect PC (holds its last value otherwise)
//   br_full          : fewer than N free training slots; issue must stall
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int UPD_W = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  EX_BR_RESULT     ex_br_in [N],
  output EX_BP_PACKET     ex_bp_packet_out [N],
  output logic            squash_flag,
  output logic [XLEN-1:0] squash_pc,
  output logic            br_full
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [N-1:0]     live;
  logic [N-1:0]     enq_valid;
  EX_BP_PACKET      enq_data [N];
  logic             sq_hit;
  logic [XLEN-1:0]  sq_target;
  logic [CNT_W-1:0] count;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      live[i]     = ex_br_in[i].valid &
                    (ex_br_in[i].cond_branch | ex_br_in[i].uncond_branch);
      enq_data[i] = make_record(ex_br_in[i]);
    end
  end

  // Walk lanes oldest first. The first mispredict is itself enqueued, but
  // everything younger is wrong-path. During a squash cycle every lane is
  // wrong-path, which also keeps squash_flag to a single-cycle pulse.
  always_comb begin
    enq_valid = '0;
    sq_hit    = 1'b0;
    sq_target = '0;
    for (int i = 0; i < N; i++) begin
      if (live[i] && !squash_flag && !sq_hit) begin
        enq_valid[i] = 1'b1;
        if (actual_npc(ex_br_in[i]) != ex_br_in[i].pred_NPC) begin
          sq_hit    = 1'b1;
          sq_target = actual_npc(ex_br_in[i]);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      squash_flag <= 1'b0;
      squash_pc   <= '0;
    end else begin
      squash_flag <= sq_hit;
      if (sq_hit) squash_pc <= sq_target;
    end
  end

  br_train_fifo #(
    .DEPTH (DEPTH),
    .LANES (N),
    .UPD_W (UPD_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (enq_valid),
    .enq_data  (enq_data),
    .deq_data  (ex_bp_packet_out),
    .count     (count)
  );

  assign br_full = (CNT_W'(DEPTH) - count) < CNT_W'(N);

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  localparam int DEPTH = 8;
  localparam int UPD_W = 1;

  logic            clock = 1'b0;
  logic            reset;
  EX_BR_RESULT     ex_br_in [N];
  EX_BP_PACKET     ex_bp_packet_out [N];
  logic            squash_flag;
  logic [XLEN-1:0] squash_pc;
  logic            br_full;

  int tests  = 0;
  int failed = 0;

  // Reference model: a queue of training records plus the pending squash.
  EX_BP_PACKET     q [$];
  logic            m_flag;
  logic [XLEN-1:0] m_pc;
  EX_BR_RESULT     stim [N];
  int              pc_seq;

  branch_resolve #(.DEPTH(DEPTH), .UPD_W(UPD_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .ex_br_in         (ex_br_in),
    .ex_bp_packet_out (ex_bp_packet_out),
    .squash_flag      (squash_flag),
    .squash_pc        (squash_pc),
    .br_full          (br_full)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int shown;
    shown = (q.size() < UPD_W) ? q.size() : UPD_W;
    check({tag, "/squash_flag"}, 128'(squash_flag), 128'(m_flag));
    if (m_flag) check({tag, "/squash_pc"}, 128'(squash_pc), 128'(m_pc));
    check({tag, "/br_full"}, 128'(br_full), 128'((DEPTH - q.size()) < N));
    for (int j = 0; j < N; j++) begin
      if (j < shown) check({tag, "/lane"}, 128'(ex_bp_packet_out[j]), 128'(q[j]));
      else           check({tag, "/idle_lane"}, 128'(ex_bp_packet_out[j]), 128'(0));
    end
  endtask

  // Applies the rules to the inputs seen at one clock edge.
  task automatic model_update();
    EX_BP_PACKET     fresh [$];
    EX_BP_PACKET     rec;
    int              free_slots;
    int              deq;
    logic            hit;
    logic            tkn;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] tgt;
    if (reset) begin
      q.delete();
      m_flag = 1'b0;
      m_pc   = '0;
    end else begin
      free_slots = DEPTH - q.size();
      deq        = (q.size() < UPD_W) ? q.size() : UPD_W;
      hit        = 1'b0;
      tgt        = m_pc;
      if (!m_flag) begin
        for (int i = 0; i < N; i++) begin
          if (!hit && stim[i].valid && (stim[i].cond_branch || stim[i].uncond_branch)) begin
            tkn = stim[i].uncond_branch || stim[i].taken;
            npc = tkn ? stim[i].target_PC : stim[i].PC + 32'd4;
            rec.cond_branch_en    = stim[i].cond_branch;
            rec.branch_en         = tkn;
            rec.cond_branch_taken = stim[i].cond_branch && stim[i].taken;
            rec.PC                = stim[i].PC;
            rec.target_PC         = stim[i].target_PC;
            if (fresh.size() < free_slots) fresh.push_back(rec);
            if (npc != stim[i].pred_NPC) begin
              hit = 1'b1;
              tgt = npc;
            end
          end
        end
      end
      repeat (deq) void'(q.pop_front());
      foreach (fresh[k]) q.push_back(fresh[k]);
      m_flag = hit;
      m_pc   = tgt;
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < N; i++) stim[i] = '0;
  endtask

  task automatic set_lane(input int i, input logic cb, input logic ub, input logic tk,
                          input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                          input logic [XLEN-1:0] pred);
    stim[i].valid         = 1'b1;
    stim[i].cond_branch   = cb;
    stim[i].uncond_branch = ub;
    stim[i].taken         = tk;
    stim[i].PC            = pc;
    stim[i].target_PC     = tgt;
    stim[i].pred_NPC      = pred;
  endtask

  // Check what is visible now, present the next inputs, clock once.
  task automatic step(input string tag);
    check_outputs(tag);
    for (int i = 0; i < N; i++) ex_br_in[i] = stim[i];
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  // Correctly predicted conditional not-taken branches at sequential PCs.
  task automatic fill_lanes(input int lanes);
    clear_stim();
    for (int i = 0; i < lanes; i++) begin
      set_lane(i, 1'b1, 1'b0, 1'b0, 32'h1000 + 32'(pc_seq * 4), 32'h8000, 32'h1000 + 32'(pc_seq * 4 + 4));
      pc_seq++;
    end
  endtask

  task automatic rand_stim();
    int              kind;
    logic            tkn;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] npc;
    clear_stim();
    if ((DEPTH - q.size()) >= N) begin
      for (int i = 0; i < N; i++) begin
        kind = int'($urandom_range(0, 4));
        pc   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
        tgt  = $urandom & 32'hFFFF_FFFC;
        tkn  = 1'($urandom_range(0, 1));
        npc  = (kind == 4 || tkn) ? tgt : pc + 32'd4;
        set_lane(i, kind == 1 || kind == 2 || kind == 3, kind == 4, tkn, pc, tgt,
                 ($urandom_range(0, 5) == 0) ? npc ^ 32'h0000_0010 : npc);
        stim[i].valid = ($urandom_range(0, 4) != 0);
      end
    end
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 4 * DEPTH && q.size() != 0; c++) begin
      clear_stim();
      step(tag);
    end
    check({tag, "/drained"}, 128'(q.size()), 128'(0));
  endtask

  initial begin
    pc_seq = 0;
    reset  = 1'b1;
    clear_stim();
    for (int i = 0; i < N; i++) ex_br_in[i] = '0;
    repeat (2) @(posedge clock);
    q.delete();
    m_flag = 1'b0;
    m_pc   = '0;
    @(negedge clock);
    check("reset/squash_pc", 128'(squash_pc), 128'(0));
    check_outputs("reset");
    reset = 1'b0;
    step("idle");
    step("idle2");

    // Conditional taken, predicted fall-through.
    clear_stim();
    set_lane(0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h200, 32'h104);
    step("mis_taken");
    check("mis_taken/flag", 128'(squash_flag), 128'(1));
    check("mis_taken/pc", 128'(squash_pc), 128'(32'h200));
    check("mis_taken/record", 128'(ex_bp_packet_out[0]), {61'd0, 3'b111, 32'h100, 32'h200});

    // A mispredicting lane during the squash cycle is wrong-path.
    clear_stim();
    set_lane(0, 1'b1, 1'b0, 1'b1, 32'h300, 32'h400, 32'h304);
    step("during_squash");
    clear_stim();
    step("after_squash");
    check("after_squash/flag", 128'(squash_flag), 128'(0));
    check("after_squash/empty", 128'(ex_bp_packet_out[0].cond_branch_en), 128'(0));
    drain("drain1");

    // Lane 1 mispredicts not-taken; lane 2 is wrong-path.
    clear_stim();
    set_lane(0, 1'b1, 1'b0, 1'b0, 32'h30, 32'h900, 32'h34);
    set_lane(1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h1000, 32'h80);
    set_lane(2, 1'b0, 1'b1, 1'b0, 32'h50, 32'h90, 32'h90);
    step("mid_mis");
    check("mid_mis/pc", 128'(squash_pc), 128'(32'h44));
    check("mid_mis/first", 128'(ex_bp_packet_out[0].PC), 128'(32'h30));
    clear_stim();
    step("mid_mis2");
    check("mid_mis/second", 128'(ex_bp_packet_out[0].PC), 128'(32'h40));
    step("mid_mis3");
    check("mid_mis/no_lane2", 128'(ex_bp_packet_out[0].branch_en), 128'(0));
    drain("drain2");

    // PC + 4 wraps at 2^32.
    clear_stim();
    set_lane(0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h10, 32'h1000);
    step("wrap");
    check("wrap/pc", 128'(squash_pc), 128'(0));
    drain("drain3");

    // Fill with N branches per cycle while there is room; drain one per cycle.
    for (int c = 0; c < 4; c++) begin
      if ((DEPTH - q.size()) >= N) fill_lanes(N);
      else clear_stim();
      step("fill");
    end
    check("fill/br_full", 128'(br_full), 128'(1));
    drain("drain4");

    // Reset in the middle of a drain with five records queued.
    fill_lanes(N);
    step("pre_reset_a");
    fill_lanes(2);
    step("pre_reset_b");
    check("pre_reset/count", 128'(q.size()), 128'(5));
    reset = 1'b1;
    clear_stim();
    step("reset_edge");
    reset = 1'b0;
    check("post_reset/lane0", 128'(ex_bp_packet_out[0]), 128'(0));
    check("post_reset/br_full", 128'(br_full), 128'(0));
    step("post_reset1");
    step("post_reset2");

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      rand_stim();
      step("rand");
    end
    drain("drain5");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
